// File: rtl/f_to_b.sv
// Inverts F = k*a*B/sqrt(b+c*B^2) to get B = F*sqrt(b/D), D = (k*a)^2 - c*F^2.
// Optional round-to-nearest square root under `F_TO_B_ROUND_EN`.
module f_to_b (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] freq,
  input  logic [31:0] a_coeff,
  input  logic [31:0] b_coeff,
  input  logic [31:0] c_coeff,
  input  logic [7:0]  k_coeff,
  output logic [31:0] b_field,
  output logic        ready,
  output logic        busy,
  output logic        overflow,
  output logic        invalid
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL1  = 3'd1;
  localparam logic [2:0] MUL2  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DIV   = 3'd4;
  localparam logic [2:0] SQRT  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]  state;

  logic [31:0] f_r, a_r, b_r, c_r;
  logic [7:0]  k_r;
  logic [63:0] f_sq;
  logic [39:0] ka;
  logic [79:0] p_r;
  logic [95:0] q_r;
  logic [95:0] n_r;

  logic [79:0] div_d;
  logic [79:0] rem;
  // Dividend low bits shift out of the top while quotient bits shift in at the bottom.
  logic [63:0] dlow;
  logic [5:0]  cnt;

  logic [63:0] rad;
  logic [32:0] srem;
  logic [31:0] root;
  logic        fast_path;

  logic [79:0] d_val;
  logic        q_ge_p;
  logic        n_ovf;
  logic [80:0] rem_sh;
  logic        div_ge;
  logic [34:0] s_sh;
  logic [34:0] trial;
  logic        sq_ge;
  logic [31:0] root_out;
  logic        root_sat;

  always_comb begin
    d_val  = p_r - q_r[79:0];
    q_ge_p = q_r >= {16'b0, p_r};
    n_ovf  = n_r >= {2'b0, d_val, 14'b0};
    rem_sh = {rem, dlow[63]};
    div_ge = rem_sh >= {1'b0, div_d};
    s_sh   = {srem, rad[63:62]};
    trial  = {1'b0, root, 2'b01};
    sq_ge  = s_sh >= trial;
  end

  // srem holds R - s^2 once the root is complete.
  always_comb begin
    root_out = root;
    root_sat = 1'b0;
`ifdef F_TO_B_ROUND_EN
    if (srem > {1'b0, root}) begin
      if (&root) root_sat = 1'b1;
      else       root_out = root + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      f_r       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      k_r       <= '0;
      f_sq      <= '0;
      ka        <= '0;
      p_r       <= '0;
      q_r       <= '0;
      n_r       <= '0;
      div_d     <= '0;
      rem       <= '0;
      dlow      <= '0;
      cnt       <= '0;
      rad       <= '0;
      srem      <= '0;
      root      <= '0;
      fast_path <= 1'b0;
      b_field   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            f_r       <= freq;
            a_r       <= a_coeff;
            b_r       <= b_coeff;
            c_r       <= c_coeff;
            k_r       <= k_coeff;
            ready     <= 1'b0;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
            fast_path <= 1'b0;
            busy      <= 1'b1;
            state     <= MUL1;
          end
        end

        MUL1: begin
          f_sq  <= {32'b0, f_r} * {32'b0, f_r};
          ka    <= {32'b0, k_r} * {8'b0, a_r};
          state <= MUL2;
        end

        MUL2: begin
          p_r   <= {40'b0, ka} * {40'b0, ka};
          q_r   <= {64'b0, c_r} * {32'b0, f_sq};
          n_r   <= {64'b0, b_r} * {32'b0, f_sq};
          state <= CHECK;
        end

        CHECK: begin
          if (q_ge_p) begin
            invalid   <= 1'b1;
            fast_path <= 1'b1;
            state     <= DONE;
          end else if (n_ovf) begin
            overflow  <= 1'b1;
            fast_path <= 1'b1;
            state     <= DONE;
          end else begin
            // N < D*2^14 guarantees the top partial remainder is below D and R fits 64 bits.
            div_d <= d_val;
            rem   <= n_r[93:14];
            dlow  <= {n_r[13:0], 50'b0};
            cnt   <= '0;
            state <= DIV;
          end
        end

        DIV: begin
          rem  <= div_ge ? 80'(rem_sh - {1'b0, div_d}) : rem_sh[79:0];
          dlow <= {dlow[62:0], div_ge};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            rad   <= {dlow[62:0], div_ge};
            srem  <= '0;
            root  <= '0;
            state <= SQRT;
          end
        end

        SQRT: begin
          srem <= sq_ge ? 33'(s_sh - trial) : s_sh[32:0];
          root <= {root[30:0], sq_ge};
          rad  <= {rad[61:0], 2'b00};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end

        DONE: begin
          if (invalid) begin
            b_field <= '0;
          end else if (fast_path) begin
            b_field <= '1;
          end else begin
            b_field <= root_sat ? 32'hFFFF_FFFF : root_out;
            if (root_sat) overflow <= 1'b1;
          end
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
